// File: rtl/xo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : xo_pkg                                                   |
// | Purpose  : Shared constants for the noughts-and-crosses game logic: |
// |            FSM state codes, side codes, winning-line table and a    |
// |            cursor column helper.                                    |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package xo_pkg;

  // FSM state codes, also exported on the state output
  localparam logic [2:0] ST_SPLASH = 3'd0;
  localparam logic [2:0] ST_PLAY   = 3'd1;
  localparam logic [2:0] ST_EVAL   = 3'd2;
  localparam logic [2:0] ST_WIN    = 3'd3;
  localparam logic [2:0] ST_TIE    = 3'd4;

  localparam logic SIDE_X = 1'b0;
  localparam logic SIDE_O = 1'b1;

  localparam int CELL_COUNT = 9;
  localparam int LINE_COUNT = 8;

  // Winning triples, row-major cell indices; order sets checker priority
  localparam logic [3:0] WIN_LINES [LINE_COUNT][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Column (0..2) of a row-major cell index, avoids a modulo operator
  function automatic logic [1:0] cell_col(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: cell_col = 2'd0;
      4'd1, 4'd4, 4'd7: cell_col = 2'd1;
      default:          cell_col = 2'd2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/xo_line_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : xo_line_checker                                          |
// | Purpose  : Combinational three-in-a-row detector. The first line in |
// |            table order that is fully occupied by one side wins.     |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module xo_line_checker
  import xo_pkg::*;
(
  input  logic [8:0] checked,
  input  logic [8:0] sign,
  output logic       line_found,
  output logic       line_winner
);

  // Priority scan over the line table; later hits are masked by the first
  always_comb begin
    line_found  = 1'b0;
    line_winner = SIDE_X;
    for (int k = 0; k < LINE_COUNT; k++) begin
      if (!line_found &&
          checked[WIN_LINES[k][0]] && checked[WIN_LINES[k][1]] && checked[WIN_LINES[k][2]] &&
          (sign[WIN_LINES[k][0]] == sign[WIN_LINES[k][1]]) &&
          (sign[WIN_LINES[k][0]] == sign[WIN_LINES[k][2]])) begin
        line_found  = 1'b1;
        line_winner = sign[WIN_LINES[k][0]];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xo_game_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : xo_game_sequencer                                        |
// | Purpose  : Game-flow controller: board, cursor, turn, scores and    |
// |            the SPLASH/PLAY/EVAL/WIN/TIE state machine.              |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module xo_game_sequencer
  import xo_pkg::*;
#(
  parameter int SPLASH_TICKS = 4,
  parameter int SCORE_MAX    = 99,
  parameter int CURSOR_HOME  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic       clear_scores,
  output logic [3:0] cursor_index,
  output logic [8:0] checked,
  output logic [8:0] sign,
  output logic       turn,
  output logic [2:0] state,
  output logic       show_splash,
  output logic       game_over,
  output logic       winner_valid,
  output logic       winner,
  output logic [6:0] x_score,
  output logic [6:0] o_score
);

  localparam logic [3:0] c_SPLASH_LAST = 4'(SPLASH_TICKS - 1);
  localparam logic [3:0] c_HOME        = 4'(CURSOR_HOME);
  localparam logic [3:0] c_FULL        = 4'(CELL_COUNT);
  localparam logic [6:0] c_SCORE_MAX   = 7'(SCORE_MAX);

  logic [2:0] r_state;
  logic [3:0] r_cursor;
  logic [8:0] r_checked;
  logic [8:0] r_sign;
  logic       r_turn;
  logic [3:0] r_move_count;
  logic [3:0] r_splash_cnt;
  logic       r_winner;
  logic [6:0] r_x_score;
  logic [6:0] r_o_score;
  logic       w_line_found;
  logic       w_line_winner;
  logic       w_score_event;

  xo_line_checker u_checker (
    .checked     (r_checked),
    .sign        (r_sign),
    .line_found  (w_line_found),
    .line_winner (w_line_winner)
  );

  // A round is scored only on the single EVAL cycle that finds a line
  assign w_score_event = (r_state == ST_EVAL) && w_line_found;

  // Main FSM plus the board, cursor and turn it owns
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_SPLASH;
      r_cursor     <= c_HOME;
      r_checked    <= '0;
      r_sign       <= '0;
      r_turn       <= SIDE_X;
      r_move_count <= '0;
      r_splash_cnt <= '0;
      r_winner     <= SIDE_X;
    end else begin
      case (r_state)
        ST_SPLASH: begin
          if (btn_confirm) begin
            r_state      <= ST_PLAY;
            r_splash_cnt <= '0;
          end else if (tick_1hz) begin
            if (r_splash_cnt == c_SPLASH_LAST) begin
              r_state      <= ST_PLAY;
              r_splash_cnt <= '0;
            end else begin
              r_splash_cnt <= r_splash_cnt + 4'd1;
            end
          end
        end
        ST_PLAY: begin
          if (btn_confirm) begin
            // Occupied cell: the press is swallowed and nothing changes
            if (!r_checked[r_cursor]) begin
              r_checked[r_cursor] <= 1'b1;
              r_sign[r_cursor]    <= r_turn;
              r_turn              <= ~r_turn;
              r_move_count        <= r_move_count + 4'd1;
              r_state             <= ST_EVAL;
            end
          end else if (btn_up) begin
            if (r_cursor > 4'd2) r_cursor <= r_cursor - 4'd3;
          end else if (btn_down) begin
            if (r_cursor < 4'd6) r_cursor <= r_cursor + 4'd3;
          end else if (btn_left) begin
            if (cell_col(r_cursor) != 2'd0) r_cursor <= r_cursor - 4'd1;
          end else if (btn_right) begin
            if (cell_col(r_cursor) != 2'd2) r_cursor <= r_cursor + 4'd1;
          end
        end
        ST_EVAL: begin
          // Line check first so a line on the ninth move is a win
          if (w_line_found) begin
            r_state  <= ST_WIN;
            r_winner <= w_line_winner;
          end else if (r_move_count == c_FULL) begin
            r_state <= ST_TIE;
          end else begin
            r_state <= ST_PLAY;
          end
        end
        ST_WIN, ST_TIE: begin
          if (btn_confirm) begin
            r_state      <= ST_PLAY;
            r_cursor     <= c_HOME;
            r_checked    <= '0;
            r_sign       <= '0;
            r_turn       <= SIDE_X;
            r_move_count <= '0;
            r_winner     <= SIDE_X;
          end
        end
        default: begin
          r_state      <= ST_SPLASH;
          r_splash_cnt <= '0;
          r_winner     <= SIDE_X;
        end
      endcase
    end
  end

  // Saturating score counters; clear_scores beats a same-cycle increment
  always_ff @(posedge clock) begin
    if (reset || clear_scores) begin
      r_x_score <= '0;
      r_o_score <= '0;
    end else if (w_score_event) begin
      if (w_line_winner == SIDE_X) begin
        if (r_x_score < c_SCORE_MAX) r_x_score <= r_x_score + 7'd1;
      end else begin
        if (r_o_score < c_SCORE_MAX) r_o_score <= r_o_score + 7'd1;
      end
    end
  end

  assign cursor_index = r_cursor;
  assign checked      = r_checked;
  assign sign         = r_sign;
  assign turn         = r_turn;
  assign state        = r_state;
  assign show_splash  = (r_state == ST_SPLASH);
  assign game_over    = (r_state == ST_WIN) || (r_state == ST_TIE);
  assign winner_valid = (r_state == ST_WIN);
  assign winner       = r_winner;
  assign x_score      = r_x_score;
  assign o_score      = r_o_score;

endmodule
`default_nettype wire

// File: tb/tb_xo_game_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_xo_game_sequencer                                     |
// | Purpose  : Self-checking bench: directed vector table, hand-written |
// |            game scenarios and a random phase, all compared against  |
// |            a board-level reference model of the game rules.         |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_xo_game_sequencer;

  localparam int P_SPLASH = 0, P_PLAY = 1, P_EVAL = 2, P_WIN = 3, P_TIE = 4;
  localparam int SPLASH_N = 4;
  localparam int SMAX     = 99;

  logic clock = 1'b0;
  logic reset = 1'b0, tick_1hz = 1'b0, clear_scores = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_confirm = 1'b0;
  logic [3:0] cursor_index;
  logic [8:0] checked, sign;
  logic       turn, show_splash, game_over, winner_valid, winner;
  logic [2:0] state;
  logic [6:0] x_score, o_score;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  xo_game_sequencer #(.SPLASH_TICKS(SPLASH_N), .SCORE_MAX(SMAX), .CURSOR_HOME(4)) dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_confirm(btn_confirm), .clear_scores(clear_scores),
    .cursor_index(cursor_index), .checked(checked), .sign(sign), .turn(turn),
    .state(state), .show_splash(show_splash), .game_over(game_over),
    .winner_valid(winner_valid), .winner(winner), .x_score(x_score), .o_score(o_score)
  );

  // ---------------- reference model: board of owners, row/col cursor ----
  int m_cell [9];          // 0 empty, 1 X, 2 O
  int m_row, m_col, m_phase, m_ticks, m_xs, m_os, m_win;

  function automatic int occupied();
    int n = 0;
    for (int i = 0; i < 9; i++) if (m_cell[i] != 0) n++;
    return n;
  endfunction

  function automatic int owner3(int a, int b, int c);
    if (m_cell[a] != 0 && m_cell[a] == m_cell[b] && m_cell[a] == m_cell[c]) return m_cell[a];
    return 0;
  endfunction

  function automatic int line_owner();
    int w = 0;
    for (int r = 0; r < 3; r++) if (w == 0) w = owner3(3*r, 3*r+1, 3*r+2);
    for (int c = 0; c < 3; c++) if (w == 0) w = owner3(c, c+3, c+6);
    if (w == 0) w = owner3(0, 4, 8);
    if (w == 0) w = owner3(2, 4, 6);
    return w;
  endfunction

  task automatic model_new_round();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_row = 1; m_col = 1; m_win = 0;
  endtask

  task automatic model_cycle(input bit rst, input bit tick, input bit clr, input logic [4:0] b);
    int w;
    if (rst) begin
      model_new_round();
      m_phase = P_SPLASH; m_ticks = 0; m_xs = 0; m_os = 0;
      return;
    end
    case (m_phase)
      P_SPLASH: begin
        if (b[4]) begin m_phase = P_PLAY; m_ticks = 0; end
        else if (tick) begin
          m_ticks++;
          if (m_ticks == SPLASH_N) begin m_phase = P_PLAY; m_ticks = 0; end
        end
      end
      P_PLAY: begin
        if (b[4]) begin
          if (m_cell[3*m_row+m_col] == 0) begin
            m_cell[3*m_row+m_col] = (occupied() % 2 == 0) ? 1 : 2;
            m_phase = P_EVAL;
          end
        end else if (b[3]) begin if (m_row > 0) m_row--; end
        else if (b[2]) begin if (m_row < 2) m_row++; end
        else if (b[1]) begin if (m_col > 0) m_col--; end
        else if (b[0]) begin if (m_col < 2) m_col++; end
      end
      P_EVAL: begin
        w = line_owner();
        if (w != 0) begin
          m_phase = P_WIN; m_win = w - 1;
          if (w == 1 && m_xs < SMAX) m_xs++;
          if (w == 2 && m_os < SMAX) m_os++;
        end else if (occupied() == 9) m_phase = P_TIE;
        else m_phase = P_PLAY;
      end
      default: begin
        if (b[4]) begin model_new_round(); m_phase = P_PLAY; end
      end
    endcase
    if (clr) begin m_xs = 0; m_os = 0; end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [8:0] ec, es;
    for (int i = 0; i < 9; i++) begin
      ec[i] = (m_cell[i] != 0);
      es[i] = (m_cell[i] == 2);
    end
    chk("state",  32'(state), 32'(m_phase));
    chk("cursor", 32'(cursor_index), 32'(3*m_row + m_col));
    chk("board",  {14'd0, checked, sign}, {14'd0, ec, es});
    chk("turn",   32'(turn), 32'(occupied() % 2));
    chk("flags",  {28'd0, show_splash, game_over, winner_valid, winner},
                  {28'd0, m_phase == P_SPLASH, m_phase == P_WIN || m_phase == P_TIE,
                   m_phase == P_WIN, (m_phase == P_WIN) ? m_win[0] : 1'b0});
    chk("scores", {18'd0, x_score, o_score}, {18'd0, 7'(m_xs), 7'(m_os)});
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 ns later
  task automatic step(input bit rst, input bit tick, input bit clr, input logic [4:0] b);
    reset = rst; tick_1hz = tick; clear_scores = clr;
    {btn_confirm, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge clock);
    model_cycle(rst, tick, clr, b);
    #1;
    check_model();
    reset = 1'b0; tick_1hz = 1'b0; clear_scores = 1'b0;
    {btn_confirm, btn_up, btn_down, btn_left, btn_right} = 5'b0;
  endtask

  localparam logic [4:0] B_NONE = 5'b00000, B_CONF = 5'b10000, B_UP = 5'b01000,
                         B_DN = 5'b00100, B_LT = 5'b00010, B_RT = 5'b00001;

  task automatic idle(); step(1'b0, 1'b0, 1'b0, B_NONE); endtask
  task automatic press(input logic [4:0] b); step(1'b0, 1'b0, 1'b0, b); endtask

  task automatic goto_cell(input int target);
    for (int g = 0; g < 4 && m_row > target / 3; g++) press(B_UP);
    for (int g = 0; g < 4 && m_row < target / 3; g++) press(B_DN);
    for (int g = 0; g < 4 && m_col > target % 3; g++) press(B_LT);
    for (int g = 0; g < 4 && m_col < target % 3; g++) press(B_RT);
  endtask

  // Confirms on each listed cell; the last press leaves the DUT in EVAL
  task automatic play_seq(input int seq [9], input int n);
    for (int i = 0; i < n; i++) begin
      goto_cell(seq[i]);
      press(B_CONF);
      if (i < n - 1) idle();
    end
  endtask

  typedef struct {
    logic       tick;
    logic [4:0] btn;
    logic [2:0] st;
    logic [3:0] cur;
    logic       spl;
  } vec_t;
  vec_t tbl [17];

  initial begin
    int rounds;
    tbl[0]  = '{1'b1, B_NONE, 3'd0, 4'd4, 1'b1};
    tbl[1]  = '{1'b0, B_NONE, 3'd0, 4'd4, 1'b1};
    tbl[2]  = '{1'b1, B_NONE, 3'd0, 4'd4, 1'b1};
    tbl[3]  = '{1'b1, B_NONE, 3'd0, 4'd4, 1'b1};
    tbl[4]  = '{1'b1, B_NONE, 3'd1, 4'd4, 1'b0};
    tbl[5]  = '{1'b0, B_UP,   3'd1, 4'd1, 1'b0};
    tbl[6]  = '{1'b0, B_UP,   3'd1, 4'd1, 1'b0};
    tbl[7]  = '{1'b0, B_LT,   3'd1, 4'd0, 1'b0};
    tbl[8]  = '{1'b0, B_LT,   3'd1, 4'd0, 1'b0};
    tbl[9]  = '{1'b0, B_RT,   3'd1, 4'd1, 1'b0};
    tbl[10] = '{1'b0, B_RT,   3'd1, 4'd2, 1'b0};
    tbl[11] = '{1'b0, B_DN,   3'd1, 4'd5, 1'b0};
    tbl[12] = '{1'b0, B_DN,   3'd1, 4'd8, 1'b0};
    tbl[13] = '{1'b0, B_DN,   3'd1, 4'd8, 1'b0};
    tbl[14] = '{1'b0, B_RT,   3'd1, 4'd8, 1'b0};
    tbl[15] = '{1'b0, B_UP | B_LT, 3'd1, 4'd5, 1'b0};
    tbl[16] = '{1'b0, B_DN | B_RT, 3'd1, 4'd8, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    // Reset values
    step(1'b1, 1'b0, 1'b0, B_NONE);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cursor", 32'(cursor_index), 32'd4);
    chk("rst_splash", 32'(show_splash), 32'd1);

    // Splash countdown and cursor edge handling
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].tick, 1'b0, tbl[i].btn);
      chk("vec_state", 32'(state), 32'(tbl[i].st));
      chk("vec_cursor", 32'(cursor_index), 32'(tbl[i].cur));
      chk("vec_splash", 32'(show_splash), 32'(tbl[i].spl));
    end

    // X wins on the top row; result visible two cycles after confirm
    play_seq('{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5);
    chk("win_eval", 32'(state), 32'd2);
    idle();
    chk("win_state", 32'(state), 32'd3);
    chk("win_who", {30'd0, winner_valid, winner}, 32'h2);
    chk("win_score", {18'd0, x_score, o_score}, {18'd0, 7'd1, 7'd0});
    press(B_RT);
    chk("win_move_ignored", {28'(state), cursor_index}, {28'd3, 4'd2});
    press(B_CONF);
    chk("newround", {15'(state), checked, cursor_index, turn, winner},
                    {15'd1, 9'd0, 4'd4, 1'b0, 1'b0});

    // Full board without a line
    play_seq('{0, 1, 2, 4, 3, 5, 7, 6, 8}, 9);
    idle();
    chk("tie_state", 32'(state), 32'd4);
    chk("tie_score", {18'd0, x_score, o_score}, {18'd0, 7'd1, 7'd0});
    press(B_CONF);
    chk("tie_newround", {15'(state), checked, cursor_index, turn, winner},
                        {15'd1, 9'd0, 4'd4, 1'b0, 1'b0});

    // Confirm on an occupied cell is swallowed
    play_seq('{4, 0, 0, 0, 0, 0, 0, 0, 0}, 1);
    idle();
    press(B_CONF);
    chk("occ_board", {5'd0, state, checked, sign, turn}, {5'd0, 3'd1, 9'h010, 9'h000, 1'b1});
    idle();
    chk("occ_no_eval", 32'(state), 32'd1);
    play_seq('{0, 1, 2, 7, 0, 0, 0, 0, 0}, 4);
    idle();
    press(B_CONF);

    // O wins on the middle row
    play_seq('{0, 3, 1, 4, 8, 5, 0, 0, 0}, 6);
    idle();
    chk("owin", {29'd0, winner_valid, winner, 1'b0}, 32'h6);
    chk("owin_score", {18'd0, x_score, o_score}, {18'd0, 7'd2, 7'd1});
    press(B_CONF);

    // Drive X to saturation, then one more win
    rounds = 0;
    while (m_xs < SMAX && rounds < 200) begin
      play_seq('{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5);
      idle();
      press(B_CONF);
      rounds++;
    end
    chk("sat_reach", 32'(x_score), 32'd99);
    play_seq('{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5);
    idle();
    chk("sat_hold", {18'd0, x_score, o_score}, {18'd0, 7'd99, 7'd1});
    press(B_CONF);

    // clear_scores during the EVAL cycle of a win beats the increment
    play_seq('{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5);
    step(1'b0, 1'b0, 1'b1, B_NONE);
    chk("clr_eval", {15'd0, state, x_score, o_score}, {15'd0, 3'd3, 7'd0, 7'd0});
    press(B_CONF);

    // Reset mid-game
    play_seq('{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5);
    idle();
    press(B_CONF);
    play_seq('{0, 3, 0, 0, 0, 0, 0, 0, 0}, 2);
    idle();
    goto_cell(8);
    step(1'b1, 1'b0, 1'b0, B_CONF);
    chk("midrst", {2'd0, state, cursor_index, checked, sign, turn, show_splash, winner},
                  {2'd0, 3'd0, 4'd4, 9'd0, 9'd0, 1'b0, 1'b1, 1'b0});
    chk("midrst_score", {18'd0, x_score, o_score}, 32'd0);

    // Random phase against the model
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] b;
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) b = 5'(1 << r);
      else if (r == 5) b = 5'($urandom_range(0, 31));
      else if (r == 6) b = B_CONF;
      else b = B_NONE;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) == 0, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
